// File: rtl/traffic_pkg.sv
// traffic_pkg: state encoding and lamp codes shared by the traffic sequencer.
//   state_t : ALL_RED=0, GREEN=1, YELLOW=2, FLASH_ON=3, FLASH_OFF=4
//   LAMP_*  : per-way {R,G,Y} lamp patterns
package traffic_pkg;
    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        GREEN     = 3'd1,
        YELLOW    = 3'd2,
        FLASH_ON  = 3'd3,
        FLASH_OFF = 3'd4
    } state_t;
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: phase duration counter.
//   clock, reset : clock and synchronous active-high reset
//   en           : advance the count on this cycle
//   hold         : freeze the count even when enabled
//   clear        : restart at 0 (wins over hold)
//   limit        : phase duration in cycles (1..2**CNT_W)
//   done         : count has reached limit-1
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             hold,
    input  logic             clear,
    input  logic [CNT_W:0]   limit,
    output logic             done
);
    logic [CNT_W-1:0] count;
    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (en && !hold)
            count <= count + 1'b1;
    end
    assign done = {1'b0, count} == limit - 1'b1;
endmodule

// File: rtl/traffic_sequencer_n.sv
// traffic_sequencer_n: R/G/Y lamp sequencer for NUM_WAYS approaches with
// demand-driven round-robin grants, all-red clearance, emergency pre-emption
// and night-mode flashing yellow.
//   clock, reset : clock and synchronous active-high reset
//   enable       : 0 freezes state, counter and outputs
//   req          : per-way demand
//   night_mode   : request flashing-yellow operation
//   emergency    : pre-emption request toward emg_way (ignored if out of range)
//   light        : way i lamps at [3i+2:3i] = {R,G,Y}
//   active_way   : way currently / last granted green
//   phase        : current state (traffic_pkg::state_t)
//   phase_start  : one-cycle pulse on the first cycle of each GREEN
module traffic_sequencer_n
    import traffic_pkg::*;
#(
    parameter int NUM_WAYS      = 2,
    parameter int GREEN_CYCLES  = 8,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_CYCLES = 1,
    parameter int FLASH_HALF    = 4,
    parameter int CNT_W         = 8,
    localparam int WAY_W        = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_WAYS-1:0]   req,
    input  logic                  night_mode,
    input  logic                  emergency,
    input  logic [WAY_W-1:0]      emg_way,
    output logic [3*NUM_WAYS-1:0] light,
    output logic [WAY_W-1:0]      active_way,
    output logic [2:0]            phase,
    output logic                  phase_start
);
    localparam logic [CNT_W:0] G_LIM = (CNT_W+1)'(GREEN_CYCLES);
    localparam logic [CNT_W:0] Y_LIM = (CNT_W+1)'(YELLOW_CYCLES);
    localparam logic [CNT_W:0] A_LIM = (CNT_W+1)'(ALLRED_CYCLES);
    localparam logic [CNT_W:0] F_LIM = (CNT_W+1)'(FLASH_HALF);
    if (NUM_WAYS < 2 || NUM_WAYS > 8) begin : g_bad_ways
        $error("NUM_WAYS must be 2..8");
    end
    if (GREEN_CYCLES < 1 || GREEN_CYCLES > 2**CNT_W || YELLOW_CYCLES < 1 || YELLOW_CYCLES > 2**CNT_W ||
        ALLRED_CYCLES < 1 || ALLRED_CYCLES > 2**CNT_W || FLASH_HALF < 1 || FLASH_HALF > 2**CNT_W) begin : g_bad_dur
        $error("every phase duration must be 1..2**CNT_W");
    end
    state_t                state, nstate;
    logic [WAY_W-1:0]      nway, rr_way;
    logic [CNT_W:0]        limit;
    logic [3*NUM_WAYS-1:0] nlight;
    logic                  done, hold, clear, emg_ok, found;
    assign emg_ok = emergency && (32'(emg_way) < NUM_WAYS);
    assign limit  = state == GREEN ? G_LIM : state == YELLOW ? Y_LIM : state == ALL_RED ? A_LIM : F_LIM;
    assign phase  = state;
    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clock (clock),
        .reset (reset),
        .en    (enable),
        .hold  (hold),
        .clear (clear),
        .limit (limit),
        .done  (done)
    );
    // First requester after active_way, wrapping; plain rotation when nobody asks.
    always_comb begin
        rr_way = WAY_W'((32'(active_way) + 1) % NUM_WAYS);
        found  = 1'b0;
        for (int k = 1; k <= NUM_WAYS; k++) begin
            if (!found && req[WAY_W'((32'(active_way) + k) % NUM_WAYS)]) begin
                found  = 1'b1;
                rr_way = WAY_W'((32'(active_way) + k) % NUM_WAYS);
            end
        end
    end
    always_comb begin
        nstate = state;
        nway   = active_way;
        clear  = 1'b0;
        hold   = 1'b0;
        if (enable) begin
            case (state)
                ALL_RED: if (done) begin
                    clear  = 1'b1;
                    nstate = (emg_ok || !night_mode) ? GREEN : FLASH_ON;
                    nway   = emg_ok ? emg_way : night_mode ? active_way : rr_way;
                end
                // Emergency toward the lit way pins the green without touching the count.
                GREEN: if (emg_ok && emg_way == active_way) hold = 1'b1;
                       else if (emg_ok || done) begin
                           clear  = 1'b1;
                           nstate = YELLOW;
                       end
                YELLOW: if (done) begin
                    clear  = 1'b1;
                    nstate = ALL_RED;
                end
                FLASH_ON: if (emg_ok || done) begin
                    clear  = 1'b1;
                    nstate = emg_ok ? ALL_RED : FLASH_OFF;
                end
                // Night exit only sampled here so a flash pulse is never cut short.
                FLASH_OFF: if (emg_ok || done) begin
                    clear  = 1'b1;
                    nstate = (emg_ok || !night_mode) ? ALL_RED : FLASH_ON;
                end
                default: begin
                    clear  = 1'b1;
                    nstate = ALL_RED;
                end
            endcase
        end
    end
    // Lamps are decoded from the next state so the registered lights match phase.
    always_comb begin
        nlight = {NUM_WAYS{LAMP_RED}};
        for (int i = 0; i < NUM_WAYS; i++)
            nlight[3*i +: 3] = nstate == FLASH_ON ? LAMP_YELLOW : nstate == FLASH_OFF ? LAMP_OFF :
                               WAY_W'(i) != nway ? LAMP_RED : nstate == GREEN ? LAMP_GREEN :
                               nstate == YELLOW ? LAMP_YELLOW : LAMP_RED;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ALL_RED;
            active_way  <= WAY_W'(NUM_WAYS - 1);
            light       <= {NUM_WAYS{LAMP_RED}};
            phase_start <= 1'b0;
        end else begin
            state       <= nstate;
            active_way  <= nway;
            light       <= nlight;
            phase_start <= enable && nstate == GREEN && state != GREEN;
        end
    end
endmodule

// File: tb/tb_traffic_sequencer_n.sv
// tb_traffic_sequencer_n: vector table, random run against a behavioural model, and 4/5-way checks.
module tb_traffic_sequencer_n;
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic       reset = 1'b1, enable = 1'b1, night_mode = 1'b0, emergency = 1'b0;
    logic [1:0] req = 2'b11;
    logic [0:0] emg_way = 1'b0;
    logic [5:0] light;
    logic [0:0] active_way;
    logic [2:0] phase;
    logic       phase_start;
    traffic_sequencer_n dut (
        .clock(clock), .reset(reset), .enable(enable), .req(req), .night_mode(night_mode),
        .emergency(emergency), .emg_way(emg_way), .light(light), .active_way(active_way),
        .phase(phase), .phase_start(phase_start)
    );
    logic        reset4 = 1'b1;
    logic [3:0]  req4 = 4'b1010;
    logic [11:0] light4;
    logic [1:0]  aw4;
    logic [2:0]  ph4;
    logic        ps4;
    traffic_sequencer_n #(.NUM_WAYS(4)) dut4 (
        .clock(clock), .reset(reset4), .enable(1'b1), .req(req4), .night_mode(1'b0),
        .emergency(1'b0), .emg_way(2'd0), .light(light4), .active_way(aw4),
        .phase(ph4), .phase_start(ps4)
    );
    logic        reset5 = 1'b1;
    logic [4:0]  req5 = 5'b00001;
    logic [2:0]  emg5 = 3'd6;
    logic [14:0] light5;
    logic [2:0]  aw5;
    logic [2:0]  ph5;
    logic        ps5;
    traffic_sequencer_n #(.NUM_WAYS(5)) dut5 (
        .clock(clock), .reset(reset5), .enable(1'b1), .req(req5), .night_mode(1'b0),
        .emergency(1'b1), .emg_way(emg5), .light(light5), .active_way(aw5),
        .phase(ph5), .phase_start(ps5)
    );
    int tests = 0, fails = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    typedef struct {
        int n; bit rst, en; bit [1:0] rq; bit nt, em, ew;
        bit [5:0] lt; int aw, ph; bit ps;
    } vec_t;
    vec_t vt[$];
    function automatic vec_t mk(int n, bit rst, bit en, bit [1:0] rq, bit nt, bit em, bit ew,
                                bit [5:0] lt, int aw, int ph, bit ps);
        vec_t v;
        v.n = n; v.rst = rst; v.en = en; v.rq = rq; v.nt = nt; v.em = em; v.ew = ew;
        v.lt = lt; v.aw = aw; v.ph = ph; v.ps = ps;
        return v;
    endfunction
    // Behavioural model: phase name, way, and cycles remaining in the phase.
    localparam int AR = 0, GR = 1, YE = 2, FON = 3, FOFF = 4;
    int m_ph, m_way, m_left;
    bit m_ps;
    function automatic int dur(int ph);
        return ph == GR ? 8 : ph == YE ? 2 : ph == AR ? 1 : 4;
    endfunction
    task automatic go(int ph, int w);
        m_ph = ph; m_way = w; m_left = dur(ph); m_ps = (ph == GR);
    endtask
    function automatic int pick(bit [1:0] rq);
        for (int k = 1; k <= 2; k++)
            if (rq[(m_way + k) % 2]) return (m_way + k) % 2;
        return (m_way + 1) % 2;
    endfunction
    task automatic m_step(bit rst, bit en, bit [1:0] rq, bit nt, bit em, int ew);
        m_ps = 0;
        if (rst) begin
            m_ph = AR; m_way = 1; m_left = 1;
        end else if (en) begin
            case (m_ph)
                AR:   if (m_left > 1) m_left--; else if (em) go(GR, ew); else if (nt) go(FON, m_way); else go(GR, pick(rq));
                GR:   if (!(em && ew == m_way)) begin
                          if (em || m_left == 1) go(YE, m_way); else m_left--;
                      end
                YE:   if (m_left > 1) m_left--; else go(AR, m_way);
                FON:  if (em) go(AR, m_way); else if (m_left > 1) m_left--; else go(FOFF, m_way);
                default: if (em) go(AR, m_way); else if (m_left > 1) m_left--; else go(nt ? FON : AR, m_way);
            endcase
        end
    endtask
    function automatic bit [5:0] m_light();
        bit [5:0] l;
        for (int w = 0; w < 2; w++)
            l[3*w +: 3] = m_ph == FON ? 3'b001 : m_ph == FOFF ? 3'b000 :
                          (w != m_way || m_ph == AR) ? 3'b100 : m_ph == GR ? 3'b010 : 3'b001;
        return l;
    endfunction
    initial begin
        int got_w[$];
        int one_lamp, non_red;
        // n  rst en req  nt em ew  light      aw ph ps
        vt.push_back(mk(1,  1, 1, 2'b11, 0, 0, 0, 6'b100100, 1, 0, 0));
        vt.push_back(mk(1,  0, 1, 2'b11, 0, 0, 0, 6'b100010, 0, 1, 1));
        vt.push_back(mk(7,  0, 1, 2'b11, 0, 0, 0, 6'b100010, 0, 1, 0));
        vt.push_back(mk(1,  0, 1, 2'b11, 0, 0, 0, 6'b100001, 0, 2, 0));
        vt.push_back(mk(1,  0, 1, 2'b11, 0, 0, 0, 6'b100001, 0, 2, 0));
        vt.push_back(mk(1,  0, 1, 2'b11, 0, 0, 0, 6'b100100, 0, 0, 0));
        vt.push_back(mk(1,  0, 1, 2'b11, 0, 0, 0, 6'b010100, 1, 1, 1));
        vt.push_back(mk(7,  0, 1, 2'b11, 0, 0, 0, 6'b010100, 1, 1, 0));
        vt.push_back(mk(1,  0, 1, 2'b11, 0, 0, 0, 6'b001100, 1, 2, 0));
        vt.push_back(mk(2,  0, 1, 2'b11, 0, 0, 0, 6'b100100, 1, 0, 0));
        vt.push_back(mk(1,  0, 1, 2'b11, 0, 0, 0, 6'b100010, 0, 1, 1));
        vt.push_back(mk(11, 0, 1, 2'b01, 0, 0, 0, 6'b100010, 0, 1, 1));
        vt.push_back(mk(5,  0, 1, 2'b01, 0, 0, 0, 6'b100010, 0, 1, 0));
        vt.push_back(mk(6,  0, 1, 2'b01, 0, 0, 0, 6'b100010, 0, 1, 1));
        vt.push_back(mk(3,  0, 1, 2'b01, 0, 0, 0, 6'b100010, 0, 1, 0));
        vt.push_back(mk(1,  0, 1, 2'b01, 0, 1, 1, 6'b100001, 0, 2, 0));
        vt.push_back(mk(1,  0, 1, 2'b01, 0, 1, 1, 6'b100001, 0, 2, 0));
        vt.push_back(mk(1,  0, 1, 2'b01, 0, 1, 1, 6'b100100, 0, 0, 0));
        vt.push_back(mk(1,  0, 1, 2'b01, 0, 1, 1, 6'b010100, 1, 1, 1));
        vt.push_back(mk(20, 0, 1, 2'b01, 0, 1, 1, 6'b010100, 1, 1, 0));
        vt.push_back(mk(7,  0, 1, 2'b01, 0, 0, 0, 6'b010100, 1, 1, 0));
        vt.push_back(mk(1,  0, 1, 2'b01, 0, 0, 0, 6'b001100, 1, 2, 0));
        vt.push_back(mk(1,  0, 1, 2'b01, 0, 0, 0, 6'b001100, 1, 2, 0));
        vt.push_back(mk(1,  0, 1, 2'b01, 0, 0, 0, 6'b100100, 1, 0, 0));
        vt.push_back(mk(1,  0, 1, 2'b01, 1, 0, 0, 6'b001001, 1, 3, 0));
        vt.push_back(mk(3,  0, 1, 2'b01, 1, 0, 0, 6'b001001, 1, 3, 0));
        vt.push_back(mk(1,  0, 1, 2'b01, 1, 0, 0, 6'b000000, 1, 4, 0));
        vt.push_back(mk(4,  0, 1, 2'b01, 1, 0, 0, 6'b001001, 1, 3, 0));
        vt.push_back(mk(3,  0, 1, 2'b01, 0, 0, 0, 6'b001001, 1, 3, 0));
        vt.push_back(mk(1,  0, 1, 2'b01, 0, 0, 0, 6'b000000, 1, 4, 0));
        vt.push_back(mk(3,  0, 1, 2'b01, 0, 0, 0, 6'b000000, 1, 4, 0));
        vt.push_back(mk(1,  0, 1, 2'b01, 0, 0, 0, 6'b100100, 1, 0, 0));
        vt.push_back(mk(1,  0, 1, 2'b01, 0, 0, 0, 6'b100010, 0, 1, 1));
        vt.push_back(mk(2,  0, 1, 2'b01, 0, 0, 0, 6'b100010, 0, 1, 0));
        vt.push_back(mk(5,  0, 0, 2'b01, 0, 0, 0, 6'b100010, 0, 1, 0));
        vt.push_back(mk(5,  0, 1, 2'b01, 0, 0, 0, 6'b100010, 0, 1, 0));
        vt.push_back(mk(1,  0, 1, 2'b01, 0, 0, 0, 6'b100001, 0, 2, 0));
        vt.push_back(mk(1,  1, 1, 2'b01, 0, 0, 0, 6'b100100, 1, 0, 0));
        vt.push_back(mk(1,  0, 1, 2'b01, 0, 0, 0, 6'b100010, 0, 1, 1));
        foreach (vt[i]) begin
            reset = vt[i].rst; enable = vt[i].en; req = vt[i].rq;
            night_mode = vt[i].nt; emergency = vt[i].em; emg_way = vt[i].ew;
            repeat (vt[i].n) @(posedge clock);
            #1;
            chk($sformatf("vec%0d light", i), 32'(light), 32'(vt[i].lt));
            chk($sformatf("vec%0d active_way", i), 32'(active_way), vt[i].aw);
            chk($sformatf("vec%0d phase", i), 32'(phase), vt[i].ph);
            chk($sformatf("vec%0d phase_start", i), 32'(phase_start), 32'(vt[i].ps));
        end
        night_mode = 1'b0; emergency = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset  = (c == 0) || ($urandom_range(0, 199) == 0);
            enable = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 7) == 0) req = 2'($urandom);
            if ($urandom_range(0, 59) == 0) night_mode = ~night_mode;
            if (emergency ? $urandom_range(0, 14) == 0 : $urandom_range(0, 39) == 0) begin
                emergency = ~emergency;
                emg_way = 1'($urandom);
            end
            @(posedge clock);
            #1;
            m_step(reset, enable, req, night_mode, emergency, int'(emg_way));
            chk("rnd light", 32'(light), 32'(m_light()));
            chk("rnd active_way", 32'(active_way), m_way);
            chk("rnd phase", 32'(phase), m_ph);
            chk("rnd phase_start", 32'(phase_start), 32'(m_ps));
            if (m_ph != FON && m_ph != FOFF) begin
                one_lamp = 1; non_red = 0;
                for (int w = 0; w < 2; w++) begin
                    if ($countones(light[3*w +: 3]) != 1) one_lamp = 0;
                    if (light[3*w +: 3] != 3'b100) non_red++;
                end
                chk("inv one lamp per way", one_lamp, 1);
                chk("inv at most one non-red", 32'(non_red <= 1), 1);
            end
        end
        reset4 = 1'b1;
        @(posedge clock);
        #1;
        reset4 = 1'b0;
        for (int c = 0; c < 200 && got_w.size() < 4; c++) begin
            @(posedge clock);
            #1;
            if (ps4) got_w.push_back(int'(aw4));
        end
        chk("w4 grant count", got_w.size(), 4);
        for (int i = 0; i < got_w.size(); i++)
            chk($sformatf("w4 grant%0d", i), got_w[i], (i % 2 == 0) ? 1 : 3);
        reset5 = 1'b1;
        @(posedge clock);
        #1;
        reset5 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clock);
            #1;
            if (c == 1) chk("w5 first grant pulse", 32'(ps5), 1);
            if (c == 4) chk("w5 out-of-range emg ignored", 32'(light5), 32'(15'b100_100_100_100_010));
            if (c == 9) chk("w5 yellow on schedule", 32'(ph5), 2);
            if (c == 12) begin
                chk("w5 regrant way", 32'(aw5), 0);
                chk("w5 regrant pulse", 32'(ps5), 1);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
